// File: rtl/sdram_port_sched.sv
// rtl/sdram_port_sched.sv - CPU/loader arbiter for one toggle-handshake SDRAM port
module sdram_port_sched #(
    parameter int              AW          = 24,
    parameter logic [AW-1:0]   CPU_BASE    = 24'h000000,
    parameter int              MAX_CPU_RUN = 4
) (
    input  logic          clk_sys,
    input  logic          res_n,
    input  logic          cpu_cs,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [15:0]   cpu_a,
    input  logic [7:0]    cpu_d,
    output logic [7:0]    cpu_q,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_a,
    input  logic [7:0]    ld_d,
    output logic          ld_busy,
    output logic          ld_ovf,
    output logic          sd_req,
    input  logic          sd_ack,
    output logic [AW-1:0] sd_a,
    output logic [1:0]    sd_ds,
    output logic          sd_we,
    output logic [15:0]   sd_d,
    input  logic [15:0]   sd_q
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_LD   = 2'd2;

    localparam int             RW      = $clog2(MAX_CPU_RUN + 1);
    localparam logic [RW-1:0]  RUN_MAX = RW'(MAX_CPU_RUN);

    logic          prev_rd_q, prev_rd_d;
    logic          prev_wr_q, prev_wr_d;
    logic [15:0]   prev_a_q, prev_a_d;
    logic          ack_q, ack_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic [AW-1:0] cpu_lat_a_q, cpu_lat_a_d;
    logic [7:0]    cpu_lat_d_q, cpu_lat_d_d;
    logic          cpu_lat_we_q, cpu_lat_we_d;
    logic          ld_pend_q, ld_pend_d;
    logic [AW-1:0] ld_lat_a_q, ld_lat_a_d;
    logic [7:0]    ld_lat_d_q, ld_lat_d_d;
    logic          ld_busy_q, ld_busy_d;
    logic          ld_ovf_q, ld_ovf_d;
    logic [1:0]    state_q, state_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          sd_req_q, sd_req_d;
    logic [AW-1:0] sd_a_q, sd_a_d;
    logic [1:0]    sd_ds_q, sd_ds_d;
    logic          sd_we_q, sd_we_d;
    logic [15:0]   sd_d_q, sd_d_d;
    logic [7:0]    cpu_q_q, cpu_q_d;

    logic rd_evt, wr_evt, hs_idle, guard_trip, grant_cpu, grant_ld, xfer_done;

    // Event detection, arbitration, handshake tracking and latch updates
    always_comb begin
        rd_evt     = cpu_cs & cpu_oe & (~prev_rd_q | (cpu_a != prev_a_q));
        wr_evt     = cpu_cs & cpu_we & ~prev_wr_q;
        // Both the raw and the registered ack must agree so a stale ack left
        // over from before reset holds off any new issue.
        hs_idle    = (sd_ack == sd_req_q) & (ack_q == sd_req_q);
        guard_trip = ld_pend_q & (run_cnt_q == RUN_MAX);
        grant_cpu  = (state_q == ST_IDLE) & hs_idle & cpu_pend_q & ~guard_trip;
        grant_ld   = (state_q == ST_IDLE) & hs_idle & ld_pend_q &
                     (~cpu_pend_q | (run_cnt_q == RUN_MAX));
        xfer_done  = (state_q != ST_IDLE) & (ack_q == sd_req_q);

        prev_rd_d    = cpu_cs & cpu_oe;
        prev_wr_d    = cpu_cs & cpu_we;
        prev_a_d     = cpu_a;
        ack_d        = sd_ack;
        cpu_pend_d   = cpu_pend_q;
        cpu_lat_a_d  = cpu_lat_a_q;
        cpu_lat_d_d  = cpu_lat_d_q;
        cpu_lat_we_d = cpu_lat_we_q;
        ld_pend_d    = ld_pend_q;
        ld_lat_a_d   = ld_lat_a_q;
        ld_lat_d_d   = ld_lat_d_q;
        ld_busy_d    = ld_busy_q;
        ld_ovf_d     = ld_ovf_q;
        state_d      = state_q;
        run_cnt_d    = run_cnt_q;
        sd_req_d     = sd_req_q;
        sd_a_d       = sd_a_q;
        sd_ds_d      = sd_ds_q;
        sd_we_d      = sd_we_q;
        sd_d_d       = sd_d_q;
        cpu_q_d      = cpu_q_q;

        if (grant_cpu) begin
            sd_a_d     = cpu_lat_a_q;
            sd_ds_d    = cpu_lat_a_q[0] ? 2'b10 : 2'b01;
            sd_we_d    = cpu_lat_we_q;
            sd_d_d     = {cpu_lat_d_q, cpu_lat_d_q};
            sd_req_d   = ~sd_req_q;
            cpu_pend_d = 1'b0;
            state_d    = ST_CPU;
            if (ld_pend_q && run_cnt_q != RUN_MAX) begin
                run_cnt_d = run_cnt_q + 1'b1;
            end
        end

        if (grant_ld) begin
            sd_a_d    = ld_lat_a_q;
            sd_ds_d   = ld_lat_a_q[0] ? 2'b10 : 2'b01;
            sd_we_d   = 1'b1;
            sd_d_d    = {ld_lat_d_q, ld_lat_d_q};
            sd_req_d  = ~sd_req_q;
            ld_pend_d = 1'b0;
            state_d   = ST_LD;
            run_cnt_d = '0;
        end

        if (!ld_pend_q) begin
            run_cnt_d = '0;
        end

        // The issued address (not the CPU latch, which may already hold a
        // newer event) selects the returned byte lane.
        if (xfer_done) begin
            state_d = ST_IDLE;
            if (state_q == ST_CPU && !sd_we_q) begin
                cpu_q_d = sd_a_q[0] ? sd_q[15:8] : sd_q[7:0];
            end
            if (state_q == ST_LD) begin
                ld_busy_d = 1'b0;
            end
        end

        // A new event after the clear above keeps the request pending.
        if (rd_evt || wr_evt) begin
            cpu_pend_d   = 1'b1;
            cpu_lat_a_d  = CPU_BASE + AW'(cpu_a);
            cpu_lat_d_d  = cpu_d;
            cpu_lat_we_d = wr_evt;
        end

        if (ld_wr) begin
            if (ld_busy_q) begin
                ld_ovf_d = 1'b1;
            end else begin
                ld_lat_a_d = ld_a;
                ld_lat_d_d = ld_d;
                ld_pend_d  = 1'b1;
                ld_busy_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_sys) begin
        if (!res_n) begin
            prev_rd_q    <= 1'b0;
            prev_wr_q    <= 1'b0;
            prev_a_q     <= '0;
            ack_q        <= 1'b0;
            cpu_pend_q   <= 1'b0;
            cpu_lat_a_q  <= '0;
            cpu_lat_d_q  <= '0;
            cpu_lat_we_q <= 1'b0;
            ld_pend_q    <= 1'b0;
            ld_lat_a_q   <= '0;
            ld_lat_d_q   <= '0;
            ld_busy_q    <= 1'b0;
            ld_ovf_q     <= 1'b0;
            state_q      <= ST_IDLE;
            run_cnt_q    <= '0;
            sd_req_q     <= 1'b0;
            sd_a_q       <= '0;
            sd_ds_q      <= 2'b11;
            sd_we_q      <= 1'b0;
            sd_d_q       <= '0;
            cpu_q_q      <= '0;
        end else begin
            prev_rd_q    <= prev_rd_d;
            prev_wr_q    <= prev_wr_d;
            prev_a_q     <= prev_a_d;
            ack_q        <= ack_d;
            cpu_pend_q   <= cpu_pend_d;
            cpu_lat_a_q  <= cpu_lat_a_d;
            cpu_lat_d_q  <= cpu_lat_d_d;
            cpu_lat_we_q <= cpu_lat_we_d;
            ld_pend_q    <= ld_pend_d;
            ld_lat_a_q   <= ld_lat_a_d;
            ld_lat_d_q   <= ld_lat_d_d;
            ld_busy_q    <= ld_busy_d;
            ld_ovf_q     <= ld_ovf_d;
            state_q      <= state_d;
            run_cnt_q    <= run_cnt_d;
            sd_req_q     <= sd_req_d;
            sd_a_q       <= sd_a_d;
            sd_ds_q      <= sd_ds_d;
            sd_we_q      <= sd_we_d;
            sd_d_q       <= sd_d_d;
            cpu_q_q      <= cpu_q_d;
        end
    end

    assign cpu_q   = cpu_q_q;
    assign ld_busy = ld_busy_q;
    assign ld_ovf  = ld_ovf_q;
    assign sd_req  = sd_req_q;
    assign sd_a    = sd_a_q;
    assign sd_ds   = sd_ds_q;
    assign sd_we   = sd_we_q;
    assign sd_d    = sd_d_q;

endmodule

// File: tb/tb_sdram_port_sched.sv
// tb/tb_sdram_port_sched.sv - directed bench for sdram_port_sched
module tb_sdram_port_sched;

    logic        clk_sys = 1'b0;
    logic        res_n = 1'b0;
    logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_a = '0;
    logic [7:0]  cpu_d = '0;
    logic [7:0]  cpu_q;
    logic        ld_wr = 1'b0;
    logic [23:0] ld_a = '0;
    logic [7:0]  ld_d = '0;
    logic        ld_busy, ld_ovf;
    logic        sd_req;
    logic        sd_ack = 1'b0;
    logic [23:0] sd_a;
    logic [1:0]  sd_ds;
    logic        sd_we;
    logic [15:0] sd_d;
    logic [15:0] sd_q = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic model_hold = 1'b0;
    logic force_en = 1'b0;
    logic force_val = 1'b0;
    logic [42:0] log_q[$];
    int          log_cyc[$];

    sdram_port_sched dut (
        .clk_sys(clk_sys), .res_n(res_n),
        .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we),
        .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_q(cpu_q),
        .ld_wr(ld_wr), .ld_a(ld_a), .ld_d(ld_d),
        .ld_busy(ld_busy), .ld_ovf(ld_ovf),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_a(sd_a),
        .sd_ds(sd_ds), .sd_we(sd_we), .sd_d(sd_d), .sd_q(sd_q)
    );

    initial forever #5 clk_sys = ~clk_sys;

    // SDRAM port model: acks 5 cycles after a toggle, logs each issued transfer
    initial begin
        logic last_req;
        int   cnt;
        last_req = 1'b0;
        cnt = 0;
        forever begin
            @(negedge clk_sys);
            cyc++;
            if (res_n && sd_req !== last_req) begin
                log_q.push_back({sd_we, sd_a, sd_ds, sd_d});
                log_cyc.push_back(cyc);
            end
            last_req = sd_req;
            if (force_en) begin
                sd_ack = force_val;
                cnt = 0;
            end else if (!model_hold && sd_ack !== sd_req) begin
                cnt++;
                if (cnt >= 5) begin
                    sd_ack = sd_req;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ld_idle(input string tag);
        for (int k = 0; k < 50 && ld_busy; k++) step();
        check(tag, ld_busy, 1'b0);
    endtask

    task automatic ld_pulse(input logic [23:0] a, input logic [7:0] d);
        ld_wr = 1'b1; ld_a = a; ld_d = d;
        step();
        ld_wr = 1'b0;
    endtask

    initial begin
        int ld_idx;

        // Reset state
        steps(3);
        check("rst_sd_req", sd_req, 1'b0);
        check("rst_cpu_q", cpu_q, 8'h00);
        check("rst_ld_busy", ld_busy, 1'b0);
        check("rst_ld_ovf", ld_ovf, 1'b0);
        check("rst_sd_a", sd_a, 24'h0);
        check("rst_sd_ds", sd_ds, 2'b11);
        check("rst_sd_we", sd_we, 1'b0);
        check("rst_sd_d", sd_d, 16'h0);
        res_n = 1'b1;
        step();

        // Single CPU read at an odd address
        sd_q = 16'hAB12;
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h1235; cpu_d = 8'h00;
        step();
        check("rd_not_yet", sd_req, 1'b0);
        step();
        check("rd_issue_lat", sd_req, 1'b1);
        steps(30);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        check("rd_count", log_q.size(), 1);
        if (log_q.size() >= 1)
            check("rd_entry", log_q[0], {1'b0, 24'h001235, 2'b10, 16'h0000});
        check("rd_cpu_q", cpu_q, 8'hAB);
        log_q.delete(); log_cyc.delete();
        step();

        // CPU write, then read of a new address with oe held
        sd_q = 16'h77C3;
        cpu_cs = 1'b1; cpu_we = 1'b1; cpu_a = 16'h0400; cpu_d = 8'h5A;
        step();
        cpu_we = 1'b0; cpu_oe = 1'b1; cpu_a = 16'h0401; cpu_d = 8'h00;
        steps(40);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        check("wr_rd_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("wr_entry", log_q[0], {1'b1, 24'h000400, 2'b01, 16'h5A5A});
            check("wr_rd_entry", log_q[1], {1'b0, 24'h000401, 2'b10, 16'h0000});
            check("wr_rd_gap", log_cyc[1] - log_cyc[0], 7);
        end
        check("wr_rd_cpu_q", cpu_q, 8'h77);
        log_q.delete(); log_cyc.delete();
        step();

        // Loader stream
        ld_pulse(24'h010000, 8'h11);
        wait_ld_idle("ld0_busy");
        ld_pulse(24'h010001, 8'h22);
        wait_ld_idle("ld1_busy");
        ld_pulse(24'h010002, 8'h33);
        wait_ld_idle("ld2_busy");
        check("ld_count", log_q.size(), 3);
        if (log_q.size() >= 3) begin
            check("ld_entry0", log_q[0], {1'b1, 24'h010000, 2'b01, 16'h1111});
            check("ld_entry1", log_q[1], {1'b1, 24'h010001, 2'b10, 16'h2222});
            check("ld_entry2", log_q[2], {1'b1, 24'h010002, 2'b01, 16'h3333});
        end
        check("ld_ovf_clear", ld_ovf, 1'b0);
        log_q.delete(); log_cyc.delete();

        // Overflow: second pulse while busy is dropped
        ld_wr = 1'b1; ld_a = 24'h010003; ld_d = 8'h44;
        step();
        ld_a = 24'h020000; ld_d = 8'h55;
        step();
        ld_wr = 1'b0;
        wait_ld_idle("ld3_busy");
        steps(5);
        check("ovf_flag", ld_ovf, 1'b1);
        check("ovf_count", log_q.size(), 1);
        if (log_q.size() >= 1)
            check("ovf_entry", log_q[0], {1'b1, 24'h010003, 2'b10, 16'h4444});
        check("ld_keeps_cpu_q", cpu_q, 8'h77);
        log_q.delete(); log_cyc.delete();

        // Simultaneous CPU event and loader write
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h2000;
        ld_wr = 1'b1; ld_a = 24'h030000; ld_d = 8'h66;
        step();
        ld_wr = 1'b0;
        steps(40);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        check("sim_count", log_q.size(), 2);
        if (log_q.size() >= 2) begin
            check("sim_cpu_first", log_q[0], {1'b0, 24'h002000, 2'b01, 16'h0000});
            check("sim_ld_second", log_q[1], {1'b1, 24'h030000, 2'b01, 16'h6666});
            check("sim_gap", log_cyc[1] - log_cyc[0], 7);
        end
        check("sim_cpu_q", cpu_q, 8'hC3);
        log_q.delete(); log_cyc.delete();
        step();

        // Starvation guard: loader write lands after exactly 4 CPU grants
        cpu_cs = 1'b1; cpu_oe = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cpu_a = 16'h3000 + 16'(i);
            if (i == 10) begin
                ld_wr = 1'b1; ld_a = 24'h040000; ld_d = 8'h77;
            end else begin
                ld_wr = 1'b0;
            end
            step();
        end
        ld_wr = 1'b0;
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        steps(40);
        ld_idx = -1;
        for (int i = 0; i < log_q.size(); i++) begin
            if (ld_idx < 0 && log_q[i][42]) ld_idx = i;
        end
        check("starve_ld_index", ld_idx, 6);
        if (ld_idx == 6)
            check("starve_ld_entry", log_q[6], {1'b1, 24'h040000, 2'b01, 16'h7777});
        if (log_q.size() >= 8)
            check("starve_cpu_resumes", log_q[7][42], 1'b0);
        log_q.delete(); log_cyc.delete();

        // Reset mid-transfer with sd_ack held high
        force_en = 1'b1; force_val = 1'b0;
        res_n = 1'b0;
        steps(3);
        res_n = 1'b1;
        step();
        force_en = 1'b0; model_hold = 1'b1;
        check("rst2_ovf_cleared", ld_ovf, 1'b0);
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h5000;
        steps(3);
        check("mid_issue", sd_req, 1'b1);
        res_n = 1'b0; force_en = 1'b1; force_val = 1'b1;
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        steps(3);
        log_q.delete(); log_cyc.delete();
        res_n = 1'b1;
        step();
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h5001;
        steps(15);
        check("stale_ack_req", sd_req, 1'b0);
        check("stale_ack_count", log_q.size(), 0);
        sd_q = 16'h9955;
        force_val = 1'b0;
        step();
        force_en = 1'b0; model_hold = 1'b0;
        steps(30);
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        check("post_rst_count", log_q.size(), 1);
        if (log_q.size() >= 1)
            check("post_rst_entry", log_q[0], {1'b0, 24'h005001, 2'b10, 16'h0000});
        check("post_rst_cpu_q", cpu_q, 8'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_sched.md
# sdram_port_sched

Schedules a single toggle-handshake SDRAM port between two requesters in the `clk_72` domain. The first is the Oric CPU/video bus, which arrives as level `cs`/`oe`/`we` strobes plus address. The second is a byte-write loader that streams ROM or disk images into SDRAM. The block sits between `oricatmos` and the SDRAM controller's `port1_*` signals and replaces the ad-hoc edge-detect logic in the top level. CPU requests take priority; a starvation guard bounds loader latency.

## Interface
Parameters:
- `AW`, 24: SDRAM byte address width.
- `CPU_BASE`, 24'h000000: byte offset added to the 16-bit CPU address.
- `MAX_CPU_RUN`, 4: consecutive CPU grants allowed while a loader request waits.

Ports:
- `clk_sys` in 1: scheduler clock (`clk_72`).
- `res_n` in 1: synchronous reset, active-low.
- `cpu_cs` in 1: CPU RAM chip select (already masked for the ROM area).
- `cpu_oe` in 1: CPU read strobe.
- `cpu_we` in 1: CPU write strobe.
- `cpu_a` in 16: CPU byte address.
- `cpu_d` in 8: CPU write data.
- `cpu_q` out 8: CPU read data.
- `ld_wr` in 1: loader write strobe, one cycle wide.
- `ld_a` in AW: loader byte address.
- `ld_d` in 8: loader data.
- `ld_busy` out 1: loader transaction in flight.
- `ld_ovf` out 1: sticky flag; an `ld_wr` arrived while `ld_busy` was high.
- `sd_req` out 1: toggle request to the SDRAM port.
- `sd_ack` in 1: toggle acknowledge from the SDRAM port.
- `sd_a` out AW: SDRAM byte address.
- `sd_ds` out 2: byte-lane select; 2'b01 for an even address, 2'b10 for an odd address.
- `sd_we` out 1: 1 for a write, 0 for a read.
- `sd_d` out 16: write data, byte replicated as {d,d}.
- `sd_q` in 16: read data from the port.

## Operation
- **CPU event detect.** Registers `prev_rd = cs&oe`, `prev_wr = cs&we` and `prev_a = cpu_a` every cycle.
  - Read event: `cs&oe & (~prev_rd | cpu_a!=prev_a)`.
  - Write event: `cs&we & ~prev_wr`.
  - An event sets `cpu_pend` and latches address, data and direction. A later event that arrives before issue overwrites the latch (latest wins).
- **Loader capture.** `ld_wr` with `ld_busy=0` latches `ld_a`/`ld_d`, sets `ld_pend`, and drives `ld_busy` to 1. `ld_wr` with `ld_busy=1` is ignored and sets `ld_ovf`. `ld_ovf` clears only on reset.
- **State machine.** States are IDLE, CPU_XFER and LD_XFER.
  - IDLE → CPU_XFER when `cpu_pend` and the guard is not tripped.
  - IDLE → LD_XFER when `ld_pend` and either `~cpu_pend` or `run_cnt==MAX_CPU_RUN`.
  - No transition out of IDLE while `sd_req != sd_ack`; this covers a stale outstanding transfer after reset.
  - Entering XFER: drive `sd_a`, `sd_ds`, `sd_we` and `sd_d` from the latch, toggle `sd_req`, and clear the corresponding pend flag.
  - XFER → IDLE on the cycle a registered `sd_ack` equals `sd_req`.
- **Starvation guard.** `run_cnt` increments on each CPU grant while `ld_pend=1` and saturates at MAX_CPU_RUN. It resets to 0 on a loader grant or whenever `ld_pend=0`.
- **Read return.** On CPU_XFER completion of a read, `cpu_q` takes `sd_q[15:8]` if latched address bit 0 is 1, else `sd_q[7:0]`. `cpu_q` then holds until the next completed read; writes do not change it.
- **Loader completion.** `ld_busy` falls on LD_XFER completion.
- **Address mapping.** CPU address is `CPU_BASE + {8'h0, cpu_a}`, modulo 2^AW; wrap-around is permitted. Loader address is used verbatim.

## Timing
- Reset values:
  - `sd_req`=0, `cpu_q`=0, `ld_busy`=0, `ld_ovf`=0.
  - `sd_a`=0, `sd_ds`=2'b11, `sd_we`=0, `sd_d`=0.
  - State IDLE, pend flags 0, `run_cnt` 0.
- Event-to-issue latency with IDLE and no handshake mismatch:
  - 1 cycle from the detecting edge: the event registers at edge N, and `sd_req` toggles at edge N+1.
- `sd_*` outputs are stable from the `sd_req` toggle until completion.
- `cpu_q` updates 1 cycle after `sd_ack` matches.
- Simultaneous CPU event and `ld_wr` in IDLE: CPU is granted first and the loader stays pending.
- A CPU event during CPU_XFER sets `cpu_pend` and issues on the cycle after return to IDLE, which is the minimum 1-cycle IDLE gap.
- Reset asserted mid-transfer: the state goes to IDLE and `sd_req`=0. If `sd_ack`=1 afterward, the scheduler issues nothing until the SDRAM side drives `sd_ack` to 0.

## Test plan
- **Single CPU read.** Reset; `cpu_cs=1`, `cpu_oe=1`, `cpu_a=16'h1235`; the SDRAM model acks after 5 cycles with `sd_q=16'hAB12`.
  - Required: one `sd_req` toggle, `sd_a=24'h001235`, `sd_ds=2'b10`, `sd_we=0`, `cpu_q=8'hAB`.
- **CPU write, then read of a new address.** Write with `cpu_a=16'h0400`, `cpu_d=8'h5A`, then hold `oe` high while the address changes to 16'h0401.
  - Required: the write issues `sd_d=16'h5A5A` with `sd_ds=2'b01`, followed by exactly one read at 24'h000401.
- **Loader stream.** Three `ld_wr` pulses, each issued only after `ld_busy` falls, to addresses 24'h010000 through 24'h010002.
  - Required: three writes in order, `ld_ovf=0`.
  - A fourth pulse issued while `ld_busy=1` sets `ld_ovf=1` and produces no transfer.
- **Starvation guard.** Continuous CPU address changes with one `ld_wr` pending.
  - Required: the loader write is issued after exactly 4 CPU grants.
- **Simultaneous requests.** CPU event and `ld_wr` arrive in the same cycle.
  - Required: the CPU transfer is issued first and the loader transfer immediately after it completes.
- **Reset mid-transfer.** Assert `res_n=0` during CPU_XFER while the model holds `sd_ack=1`, then release reset.
  - Required: no new `sd_req` toggle until `sd_ack` returns to 0; then a pending CPU event issues normally.
